// File: rtl/toggle_bank_arb_if.sv
// -----------------------------------------------------------------------------
// toggle_bank_arb_if
// Bundles the request/response signals of the toggle bank arbiter.
//   clr_all     : global synchronous clear of the bank
//   req_valid   : per-requester request             (NREQ)
//   req_idx     : per-requester bit index           (NREQ*IDXW, slot i at [i*IDXW +: IDXW])
//   req_clr     : per-requester opcode, 0=toggle 1=clear (NREQ)
//   req_ready   : one-hot completion strobe         (NREQ)
//   q           : toggle bank contents              (NBITS)
//   grant_valid : an operation is being served
//   grant_id    : id of the served requester, 0 when idle (GIDW)
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface toggle_bank_arb_if #(
   parameter int NREQ  = 4,
   parameter int NBITS = 8
);
   localparam int IDXW = $clog2(NBITS);
   localparam int GIDW = $clog2(NREQ);

   logic                   clr_all;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*IDXW-1:0]   req_idx;
   logic [NREQ-1:0]        req_clr;
   logic [NREQ-1:0]        req_ready;
   logic [NBITS-1:0]       q;
   logic                   grant_valid;
   logic [GIDW-1:0]        grant_id;

   modport master (
      output clr_all, req_valid, req_idx, req_clr,
      input  req_ready, q, grant_valid, grant_id
   );

   modport slave (
      input  clr_all, req_valid, req_idx, req_clr,
      output req_ready, q, grant_valid, grant_id
   );
endinterface

// File: rtl/toggle_bank_arb.sv
// -----------------------------------------------------------------------------
// toggle_bank_arb
// Round-robin arbiter in front of an NBITS-wide toggle bank. A winner is picked
// in IDLE, its id/idx/opcode are latched, and the bank bit is toggled or
// cleared at the edge that ends SERVE (2 cycles per operation).
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : toggle_bank_arb_if.slave (requests in, ready/grant/q out)
// -----------------------------------------------------------------------------
module toggle_bank_arb #(
   parameter int NREQ  = 4,
   parameter int NBITS = 8
) (
   input  logic               clk,
   input  logic               rst,
   toggle_bank_arb_if.slave   bus
);
   localparam int IDXW = $clog2(NBITS);
   localparam int GIDW = $clog2(NREQ);
   localparam logic [GIDW:0]   NREQ_W  = (GIDW+1)'(NREQ);
   localparam logic [GIDW-1:0] LAST_ID = GIDW'(NREQ - 1);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t            state_reg, state_next;
   logic [NBITS-1:0]  q_reg, q_next;
   logic [GIDW-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [GIDW-1:0]   id_reg, id_next;
   logic [IDXW-1:0]   idx_reg, idx_next;
   logic              clr_reg, clr_next;

   // ---------------- round-robin search ----------------
   // Requests are rotated so that rr_ptr sits at bit 0; the lowest set bit of
   // the rotated vector is the offset of the winner from rr_ptr.
   logic [2*NREQ-1:0]           req_dbl;
   logic [NREQ-1:0]             req_rot;
   logic [NREQ-1:0]             first_hit;
   logic [GIDW-1:0][NREQ-1:0]   hit_bit;
   logic [GIDW-1:0]             win_off;
   logic [GIDW:0]               win_sum;
   logic [GIDW-1:0]             win_id;
   logic [IDXW-1:0]             idx_arr [NREQ];

   assign req_dbl = {bus.req_valid, bus.req_valid};
   assign req_rot = NREQ'(req_dbl >> rr_ptr_reg);

   genvar gi, gb;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign idx_arr[gi] = bus.req_idx[gi*IDXW +: IDXW];

         if (gi == 0) begin : g_first
            assign first_hit[gi] = req_rot[0];
         end else begin : g_rest
            assign first_hit[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
         end

         // Binary-encode the one-hot first_hit, one output bit at a time.
         for (gb = 0; gb < GIDW; gb++) begin : g_enc
            if (((gi >> gb) & 1) == 1) begin : g_one
               assign hit_bit[gb][gi] = first_hit[gi];
            end else begin : g_zero
               assign hit_bit[gb][gi] = 1'b0;
            end
         end

         assign bus.req_ready[gi] = (state_reg == SERVE) && (id_reg == GIDW'(gi));
      end

      for (gb = 0; gb < GIDW; gb++) begin : g_off
         assign win_off[gb] = |hit_bit[gb];
      end
   endgenerate

   // Offset back to an absolute id, modulo NREQ (NREQ need not be a power of 2).
   assign win_sum = {1'b0, rr_ptr_reg} + {1'b0, win_off};
   assign win_id  = (win_sum >= NREQ_W) ? GIDW'(win_sum - NREQ_W) : GIDW'(win_sum);

   // ---------------- FSM ----------------
   always_comb begin
      state_next  = state_reg;
      q_next      = q_reg;
      rr_ptr_next = rr_ptr_reg;
      id_next     = id_reg;
      idx_next    = idx_reg;
      clr_next    = clr_reg;

      case (state_reg)
         IDLE: begin
            if (|bus.req_valid) begin
               state_next = SERVE;
               id_next    = win_id;
               idx_next   = idx_arr[win_id];
               clr_next   = bus.req_clr[win_id];
            end
         end
         SERVE: begin
            q_next[idx_reg] = clr_reg ? 1'b0 : ~q_reg[idx_reg];
            rr_ptr_next     = (id_reg == LAST_ID) ? '0 : id_reg + 1'b1;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Global clear aborts whatever is in flight; the pointer must not advance.
      if (bus.clr_all) begin
         q_next      = '0;
         rr_ptr_next = rr_ptr_reg;
         state_next  = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         q_reg      <= '0;
         rr_ptr_reg <= '0;
         id_reg     <= '0;
         idx_reg    <= '0;
         clr_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         q_reg      <= q_next;
         rr_ptr_reg <= rr_ptr_next;
         id_reg     <= id_next;
         idx_reg    <= idx_next;
         clr_reg    <= clr_next;
      end
   end

   // Outputs come from registered state only.
   assign bus.q           = q_reg;
   assign bus.grant_valid = (state_reg == SERVE);
   assign bus.grant_id    = (state_reg == SERVE) ? id_reg : '0;

endmodule
